aes_key_expand: RTL and testbench

Round-key expansion and storage stage for the AES-128 datapath. It accepts one 128-bit cipher key over a valid/ready handshake and computes the FIPS-197 key schedule at one round per cycle. It stores all NR+1 round keys and serves them through a registered random-access read port to the downstream cipher round logic (AddRoundKey). It replaces per-round key regeneration: encryption rounds read stored keys by index.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_sbox.sv | 49 ++++
 rtl/aes_key_expand.sv | 204 ++++++++++++++++++++
 tb/tb_aes_key_expand.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES-128 types, constants and the GF(2^8) xtime helper.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] key_128;
    typedef logic [31:0]  aes_word;
    typedef logic [7:0]   ByteType;

    localparam int      NR        = 10;
    localparam ByteType RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic ByteType xtime(input ByteType b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Purpose  : Combinational AES S-box: GF(2^8) inverse followed by the affine map.
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    import aes_pkg::*;

    function automatic ByteType gf_mul(input ByteType a, input ByteType b);
        ByteType p;
        ByteType x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
    function automatic ByteType gf_inv(input ByteType a);
        ByteType r;
        ByteType s;
        r = 8'h01;
        s = a;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    ByteType w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand
// Purpose  : AES-128 key schedule, one round per cycle, with an NR+1 entry
//            round-key store and a registered random-access read port.
//            Optional feature macro: AES_KEY_ZEROIZE_EN (zeroize_i port).
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expand #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [127:0]     key_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic             zeroize_i,
`endif
    input  logic             rk_rd_en_i,
    input  logic [IDX_W-1:0] rk_rd_idx_i,
    output logic [127:0]     rk_o,
    output logic             rk_valid_o,
    output logic             rk_err_o,
    output logic             keys_valid_o,
    output logic             done_o,
    output logic             busy_o
);
    import aes_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NR);

    state_t           r_state;
    key_128           r_rk [0:NR];
    aes_word          r_w0, r_w1, r_w2, r_w3;
    ByteType          r_rcon;
    logic [IDX_W-1:0] r_rnd;
    logic [IDX_W:0]   r_wr_cnt;

    aes_word          w_rot, w_sub, w_temp;
    aes_word          w_n0, w_n1, w_n2, w_n3;
    key_128           w_next;
    logic             w_accept;
    logic             w_expand_wr;

    // ------------------------------------------------------------------
    // One round of the key schedule, fully combinational.
    // ------------------------------------------------------------------
    assign w_rot = {r_w3[23:0], r_w3[31:24]};

    generate
        for (genvar b = 0; b < 4; b++) begin : g_subword
            aes_sbox u_sbox (
                .i_byte (w_rot[8*b +: 8]),
                .o_byte (w_sub[8*b +: 8])
            );
        end
    endgenerate

    assign w_temp = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0   = r_w0 ^ w_temp;
    assign w_n1   = r_w1 ^ w_n0;
    assign w_n2   = r_w2 ^ w_n1;
    assign w_n3   = r_w3 ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

`ifdef AES_KEY_ZEROIZE_EN
    assign w_accept    = key_valid_i & key_ready_o & ~zeroize_i;
    assign w_expand_wr = (r_state == S_EXPAND) & ~zeroize_i;
`else
    assign w_accept    = key_valid_i & key_ready_o;
    assign w_expand_wr = (r_state == S_EXPAND);
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_w0         <= '0;
            r_w1         <= '0;
            r_w2         <= '0;
            r_w3         <= '0;
            r_rcon       <= RCON_INIT;
            r_rnd        <= '0;
            r_wr_cnt     <= '0;
            key_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            keys_valid_o <= 1'b0;
            done_o       <= 1'b0;
        end
`ifdef AES_KEY_ZEROIZE_EN
        else if (zeroize_i) begin
            r_state      <= S_IDLE;
            r_rcon       <= RCON_INIT;
            r_rnd        <= '0;
            r_wr_cnt     <= '0;
            key_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            keys_valid_o <= 1'b0;
            done_o       <= 1'b0;
        end
`endif
        else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done_o <= 1'b0;
                    if (w_accept) begin
                        r_state      <= S_EXPAND;
                        r_w0         <= key_i[127:96];
                        r_w1         <= key_i[95:64];
                        r_w2         <= key_i[63:32];
                        r_w3         <= key_i[31:0];
                        r_rcon       <= RCON_INIT;
                        r_rnd        <= IDX_W'(1);
                        r_wr_cnt     <= (IDX_W+1)'(1);
                        key_ready_o  <= 1'b0;
                        busy_o       <= 1'b1;
                        keys_valid_o <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    r_w0     <= w_n0;
                    r_w1     <= w_n1;
                    r_w2     <= w_n2;
                    r_w3     <= w_n3;
                    r_rcon   <= xtime(r_rcon);
                    r_rnd    <= r_rnd + IDX_W'(1);
                    r_wr_cnt <= r_wr_cnt + (IDX_W+1)'(1);
                    if (r_rnd == c_last_idx) begin
                        r_state      <= S_DONE;
                        key_ready_o  <= 1'b1;
                        busy_o       <= 1'b0;
                        keys_valid_o <= 1'b1;
                        done_o       <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    key_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    done_o      <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-key store
    // ------------------------------------------------------------------
`ifdef AES_KEY_ZEROIZE_EN
    always_ff @(posedge clk) begin
        if (rst || zeroize_i) begin
            for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
        end else begin
            if (w_accept)    r_rk[0]     <= key_i;
            if (w_expand_wr) r_rk[r_rnd] <= w_next;
        end
    end
`else
    // No reset on the store; wr_cnt alone decides what reads are valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_accept)    r_rk[0]     <= key_i;
            if (w_expand_wr) r_rk[r_rnd] <= w_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registered read port; sees the store and wr_cnt as they were
    // before this edge, so a read racing a restart returns the old key.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_o       <= '0;
            rk_valid_o <= 1'b0;
            rk_err_o   <= 1'b0;
        end else if (rk_rd_en_i) begin
            if (rk_rd_idx_i > c_last_idx) begin
                rk_o       <= '0;
                rk_valid_o <= 1'b0;
                rk_err_o   <= 1'b1;
            end else begin
                rk_o       <= r_rk[rk_rd_idx_i];
                rk_valid_o <= ({1'b0, rk_rd_idx_i} < r_wr_cnt);
                rk_err_o   <= 1'b0;
            end
        end else begin
            rk_valid_o <= 1'b0;
            rk_err_o   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expand
// Purpose  : Self-checking bench: FIPS-197 vectors, random keys against a
//            word-level key-schedule model, and multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic         key_valid;
    logic         key_ready;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rk;
    logic         rk_valid;
    logic         rk_err;
    logic         keys_valid;
    logic         done;
    logic         busy;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_key_expand #(.NR(10), .IDX_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_i        (key),
        .key_valid_i  (key_valid),
        .key_ready_o  (key_ready),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize_i    (zeroize),
`endif
        .rk_rd_en_i   (rd_en),
        .rk_rd_idx_i  (rd_idx),
        .rk_o         (rk),
        .rk_valid_o   (rk_valid),
        .rk_err_o     (rk_err),
        .keys_valid_o (keys_valid),
        .done_o       (done),
        .busy_o       (busy)
    );

    // ---------------- reference model ----------------
    int           exp_t [256];
    int           log_t [256];
    logic [127:0] m_rk  [0:10];

    function automatic logic [7:0] m_xtime(input logic [7:0] b);
        logic [7:0] s;
        s = b << 1;
        return s ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c   = 8'h63;
        inv = (x == 8'h00) ? 8'h00 : 8'(exp_t[(255 - log_t[x]) % 255]);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return s;
    endfunction

    task automatic model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = m_xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        int n;
        n = 0;
        key = k;
        key_valid = 1'b1;
        while (!key_ready && n < 40) begin
            tick();
            n++;
        end
        check("key_ready_for_load", key_ready, 1'b1);
        tick();
        key_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic do_read(input logic [3:0] idx);
        rd_en  = 1'b1;
        rd_idx = idx;
        tick();
        rd_en  = 1'b0;
    endtask

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] rk;
        logic         valid;
        logic         err;
    } vec_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] ka, kb, saved;

        vecs[0] = '{FIPS_KEY, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1, 1'b0};
        vecs[1] = '{FIPS_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 1'b0};
        vecs[2] = '{FIPS_KEY, 4'd0,  FIPS_KEY,                              1'b1, 1'b0};
        vecs[3] = '{128'h0,   4'd1,  128'h62636363626363636263636362636363, 1'b1, 1'b0};
        vecs[4] = '{128'h0,   4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1, 1'b0};
        vecs[5] = '{128'h0,   4'd11, 128'h0,                                1'b0, 1'b1};
        vecs[6] = '{FIPS_KEY, 4'd15, 128'h0,                                1'b0, 1'b1};

        exp_t[0] = 1;
        for (int i = 1; i < 256; i++) exp_t[i] = exp_t[i-1] ^ int'(m_xtime(8'(exp_t[i-1])));
        for (int i = 0; i < 255; i++) log_t[exp_t[i]] = i;

        rst = 1'b1; key = '0; key_valid = 1'b0; rd_en = 1'b0; rd_idx = '0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;

        check("reset_key_ready",  key_ready,  1'b1);
        check("reset_busy",       busy,       1'b0);
        check("reset_keys_valid", keys_valid, 1'b0);
        check("reset_done",       done,       1'b0);
        check("reset_rk",         rk,         128'h0);
        check("reset_rk_valid",   rk_valid,   1'b0);
        check("reset_rk_err",     rk_err,     1'b0);

        // Done timing relative to the acceptance edge E0.
        load_key(FIPS_KEY);
        check("busy_after_accept",  busy,      1'b1);
        check("ready_after_accept", key_ready, 1'b0);
        for (int c = 1; c <= 9; c++) tick();
        check("done_before_E10",  done,       1'b0);
        check("kv_before_E10",    keys_valid, 1'b0);
        tick();
        check("done_at_E10",      done,       1'b1);
        check("kv_at_E10",        keys_valid, 1'b1);
        check("ready_at_E10",     key_ready,  1'b1);
        check("busy_at_E10",      busy,       1'b0);
        tick();
        check("done_one_pulse",   done,       1'b0);
        check("kv_held",          keys_valid, 1'b1);

        for (int v = 0; v < 7; v++) begin
            load_key(vecs[v].key);
            wait_done();
            do_read(vecs[v].idx);
            check($sformatf("vec%0d_rk", v),    rk,       vecs[v].rk);
            check($sformatf("vec%0d_valid", v), rk_valid, vecs[v].valid);
            check($sformatf("vec%0d_err", v),   rk_err,   vecs[v].err);
        end

        for (int r = 0; r < 4; r++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            model(ka);
            load_key(ka);
            wait_done();
            for (int i = 0; i <= 10; i++) begin
                do_read(4'(i));
                check($sformatf("rand%0d_rk%0d", r, i), rk, m_rk[i]);
                check($sformatf("rand%0d_v%0d", r, i), rk_valid, 1'b1);
            end
        end

        // Reads racing the expansion: valid only once wr_cnt passes idx.
        ka = {$urandom, $urandom, $urandom, $urandom};
        model(ka);
        load_key(ka);
        tick();
        do_read(4'd5);
        check("early5_valid", rk_valid, 1'b0);
        do_read(4'd3);
        check("edge3_valid", rk_valid, 1'b0);
        do_read(4'd3);
        check("after3_valid", rk_valid, 1'b1);
        check("after3_rk",    rk,       m_rk[3]);
        do_read(4'd5);
        check("edge5_valid", rk_valid, 1'b0);
        do_read(4'd5);
        check("after5_valid", rk_valid, 1'b1);
        check("after5_rk",    rk,       m_rk[5]);
        do_read(4'd11);
        check("idx11_err",   rk_err,   1'b1);
        check("idx11_rk",    rk,       128'h0);
        check("idx11_valid", rk_valid, 1'b0);
        do_read(4'd5);
        check("reread5_rk", rk, m_rk[5]);
        tick();
        check("idle_valid_clr", rk_valid, 1'b0);
        check("idle_err_clr",   rk_err,   1'b0);
        check("idle_rk_hold",   rk,       m_rk[5]);
        wait_done();

        // key_valid pulsed during EXPAND is ignored.
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        model(ka);
        load_key(ka);
        tick(); tick();
        key = kb; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("ignore_ready", key_ready, 1'b0);
        check("ignore_busy",  busy,      1'b1);
        wait_done();
        do_read(4'd0);
        check("ignore_rk0",  rk, ka);
        do_read(4'd10);
        check("ignore_rk10", rk, m_rk[10]);

        // Restart from DONE with a simultaneous read of idx 0.
        saved = m_rk[0];
        key = kb; key_valid = 1'b1; rd_en = 1'b1; rd_idx = 4'd0;
        tick();
        key_valid = 1'b0; rd_en = 1'b0;
        check("restart_rk_old",   rk,         saved);
        check("restart_valid",    rk_valid,   1'b1);
        check("restart_kv_drop",  keys_valid, 1'b0);
        check("restart_busy",     busy,       1'b1);
        model(kb);
        wait_done();
        do_read(4'd0);
        check("restart_new_rk0",  rk, kb);
        do_read(4'd10);
        check("restart_new_rk10", rk, m_rk[10]);

        // Reset after E4.
        load_key(FIPS_KEY);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready",    key_ready,  1'b1);
        check("midrst_busy",     busy,       1'b0);
        check("midrst_kv",       keys_valid, 1'b0);
        check("midrst_done",     done,       1'b0);
        check("midrst_rk",       rk,         128'h0);
        check("midrst_rk_valid", rk_valid,   1'b0);
        do_read(4'd2);
        check("midrst_read2_valid", rk_valid, 1'b0);
        do_read(4'd0);
        check("midrst_read0_valid", rk_valid, 1'b0);

        load_key(FIPS_KEY);
        wait_done();
        do_read(4'd10);
        check("recover_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zero_kv",    keys_valid, 1'b0);
        check("zero_ready", key_ready,  1'b1);
        do_read(4'd0);
        check("zero_rk0",       rk,       128'h0);
        check("zero_rk0_valid", rk_valid, 1'b0);
        key = FIPS_KEY; key_valid = 1'b1; zeroize = 1'b1;
        tick();
        key_valid = 1'b0; zeroize = 1'b0;
        check("zero_prio_busy", busy, 1'b0);
        do_read(4'd0);
        check("zero_prio_rk0", rk, 128'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
